softmax_seq: RTL and testbench

SOFTMAX_SEQ -- requirements
Module: softmax_seq

---
 rtl/softmax_seq_pkg.sv | 20 ++
 rtl/softmax_seq_buf.sv | 28 ++
 rtl/softmax_seq.sv | 231 +++++++++++++++++++++++
 tb/tb_softmax_seq.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/softmax_seq_pkg.sv
// Shared types and defaults for the sequenced softmax job controller.
package softmax_seq_pkg;

    localparam int unsigned DEF_DWIDTH   = 16;
    localparam int unsigned DEF_CNT_BIT  = 16;
    localparam int unsigned DEF_ADDR_BIT = 8;

    // Most-negative element value used to pad an odd-length vector.
    localparam logic [DEF_DWIDTH-1:0] PAD_VAL = {1'b1, {(DEF_DWIDTH-1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRIME,
        S_RUN,
        S_WAIT,
        S_DRAIN,
        S_DONE
    } state_t;

endpackage

// File: rtl/softmax_seq_buf.sv
// Exp-pair buffer: simple dual-port RAM with one-cycle synchronous read.
module softmax_seq_buf
    import softmax_seq_pkg::*;
#(
    parameter int unsigned DW = 2 * DEF_DWIDTH,
    parameter int unsigned AW = DEF_ADDR_BIT
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [2**AW];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/softmax_seq.sv
// Sequences one softmax job: streams source pairs into the engine, buffers exps, drains results.
// Optional odd-length padding is enabled by defining SOFTMAX_SEQ_ODD_PAD_EN.
module softmax_seq
    import softmax_seq_pkg::*;
#(
    parameter int unsigned DWIDTH   = DEF_DWIDTH,
    parameter int unsigned CNT_BIT  = DEF_CNT_BIT,
    parameter int unsigned ADDR_BIT = DEF_ADDR_BIT
) (
    input  logic                  clk,
    input  logic                  arst_n,
    input  logic                  start,
    input  logic [CNT_BIT-1:0]    num,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic                  src_rd,
    output logic [ADDR_BIT-1:0]   src_addr,
    input  logic [2*DWIDTH-1:0]   src_data,
    output logic                  dst_we,
    output logic [ADDR_BIT-1:0]   dst_addr,
    output logic [2*DWIDTH-1:0]   dst_data,
    output logic                  sm_enable,
    output logic [DWIDTH-1:0]     sm_in0,
    output logic [DWIDTH-1:0]     sm_in1,
    output logic [DWIDTH-1:0]     sm_exp0,
    output logic [DWIDTH-1:0]     sm_exp1,
    output logic [CNT_BIT-1:0]    sm_num,
    input  logic [2*DWIDTH-1:0]   sm_exp_out,
    input  logic                  sm_exp_valid,
    input  logic                  sm_recip_valid,
    input  logic [2*DWIDTH-1:0]   sm_out,
    input  logic                  sm_valid
);

`ifdef SOFTMAX_SEQ_ODD_PAD_EN
    localparam bit PAD_EN = 1'b1;
`else
    localparam bit PAD_EN = 1'b0;
`endif

    localparam int unsigned AW    = ADDR_BIT + 1;
    localparam int unsigned DW2   = 2 * DWIDTH;
    localparam int unsigned CW    = ((CNT_BIT > ADDR_BIT) ? CNT_BIT : ADDR_BIT) + 2;
    localparam int unsigned MAX_P = 1 << ADDR_BIT;
    localparam logic [DWIDTH-1:0] PAD = {1'b1, {(DWIDTH-1){1'b0}}};

    state_t             state, state_n;
    logic [CNT_BIT-1:0] n_q, n_n;
    logic [AW-1:0]      p_q, p_n, kc, kc_n, wp, wp_n, rdp, rdp_n, rc, rc_n;
    logic               odd_q, odd_n;
    logic               rd_vld_q;
    logic [CW-1:0]      n_ext, n_pad, p_calc;
    logic               pad_job, legal, err_n;
    logic               src_rd_n;
    logic [ADDR_BIT-1:0] src_addr_n;
    logic               buf_we, buf_re;
    logic [DW2-1:0]     buf_rdata;

    // State register.
    always_ff @(posedge clk) begin
        if (!arst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next state, counters, same-cycle engine/result paths and buffer control.
    always_comb begin
        state_n    = state;
        n_n        = n_q;
        p_n        = p_q;
        odd_n      = odd_q;
        kc_n       = kc;
        wp_n       = wp;
        rdp_n      = rdp;
        rc_n       = rc;
        err_n      = 1'b0;
        buf_we     = 1'b0;
        buf_re     = 1'b0;
        dst_we     = 1'b0;
        dst_addr   = '0;
        dst_data   = '0;
        sm_in0     = '0;
        sm_in1     = '0;
        src_rd_n   = 1'b0;
        src_addr_n = '0;

        n_ext   = CW'(num);
        pad_job = PAD_EN && num[0];
        n_pad   = pad_job ? n_ext + CW'(1) : n_ext;
        p_calc  = n_pad >> 1;
        legal   = (n_ext >= CW'(2)) && (p_calc <= CW'(MAX_P)) && (!num[0] || PAD_EN);

        case (state)
            S_IDLE: begin
                if (start) begin
                    if (legal) begin
                        state_n = S_PRIME;
                        n_n     = CNT_BIT'(n_pad);
                        p_n     = AW'(p_calc);
                        odd_n   = pad_job;
                        kc_n    = '0;
                        wp_n    = '0;
                        rdp_n   = '0;
                        rc_n    = '0;
                    end else begin
                        err_n = 1'b1;
                    end
                end
            end
            S_PRIME: state_n = S_RUN;
            S_RUN: begin
                sm_in0 = src_data[DW2-1:DWIDTH];
                sm_in1 = (odd_q && (kc == p_q - AW'(1))) ? PAD : src_data[DWIDTH-1:0];
                if (kc == p_q - AW'(1)) begin
                    state_n = S_WAIT;
                end else begin
                    kc_n = kc + AW'(1);
                end
            end
            S_WAIT: begin
                if (sm_recip_valid) begin
                    if (wp < p_q) begin
                        err_n   = 1'b1;
                        state_n = S_IDLE;
                    end else begin
                        state_n = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (sm_valid && (rc < p_q)) begin
                    dst_we   = 1'b1;
                    dst_addr = ADDR_BIT'(rc);
                    // The pad element's result is meaningless; store zero in its slot.
                    dst_data = (odd_q && (rc == p_q - AW'(1)))
                             ? {sm_out[DW2-1:DWIDTH], DWIDTH'(0)} : sm_out;
                    rc_n     = rc + AW'(1);
                    if (rc_n == p_q) begin
                        state_n = S_DONE;
                    end
                end
            end
            S_DONE:  state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase

        // Exp capture; the pointer saturates instead of wrapping on a runaway engine.
        if (((state == S_RUN) || (state == S_WAIT)) && sm_exp_valid) begin
            buf_we = (wp < p_q);
            if (wp != '1) begin
                wp_n = wp + AW'(1);
            end
        end

        // Buffer read for pair rdp is issued one cycle before its data is registered out.
        buf_re = (state_n == S_DRAIN) && (rdp < p_q);
        if (buf_re) begin
            rdp_n = rdp + AW'(1);
        end

        if (state_n == S_PRIME) begin
            src_rd_n = 1'b1;
        end else if ((state_n == S_RUN) && ((kc_n + AW'(1)) < p_n)) begin
            src_rd_n   = 1'b1;
            src_addr_n = ADDR_BIT'(kc_n + AW'(1));
        end
    end

    // Job registers and registered outputs.
    always_ff @(posedge clk) begin
        if (!arst_n) begin
            n_q       <= '0;
            p_q       <= '0;
            odd_q     <= 1'b0;
            kc        <= '0;
            wp        <= '0;
            rdp       <= '0;
            rc        <= '0;
            rd_vld_q  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            sm_enable <= 1'b0;
            sm_num    <= '0;
            src_rd    <= 1'b0;
            src_addr  <= '0;
            sm_exp0   <= '0;
            sm_exp1   <= '0;
        end else begin
            n_q       <= n_n;
            p_q       <= p_n;
            odd_q     <= odd_n;
            kc        <= kc_n;
            wp        <= wp_n;
            rdp       <= rdp_n;
            rc        <= rc_n;
            rd_vld_q  <= buf_re;
            busy      <= (state_n != S_IDLE);
            done      <= (state_n == S_DONE);
            err       <= err_n;
            sm_enable <= (state_n inside {S_RUN, S_WAIT, S_DRAIN, S_DONE});
            sm_num    <= (state_n != S_IDLE) ? n_n : '0;
            src_rd    <= src_rd_n;
            src_addr  <= src_addr_n;
            if (state_n == S_IDLE) begin
                sm_exp0 <= '0;
                sm_exp1 <= '0;
            end else if (rd_vld_q) begin
                sm_exp0 <= buf_rdata[DW2-1:DWIDTH];
                sm_exp1 <= buf_rdata[DWIDTH-1:0];
            end
        end
    end

    softmax_seq_buf #(
        .DW (DW2),
        .AW (ADDR_BIT)
    ) u_buf (
        .clk   (clk),
        .we    (buf_we),
        .waddr (ADDR_BIT'(wp)),
        .wdata (sm_exp_out),
        .re    (buf_re),
        .raddr (ADDR_BIT'(rdp)),
        .rdata (buf_rdata)
    );

endmodule

// File: tb/tb_softmax_seq.sv
// Directed bench for softmax_seq with a behavioural softmax engine and source/result memories.
module tb_softmax_seq;

    logic        clk = 1'b0;
    logic        arst_n;
    logic        start;
    logic [15:0] num;
    logic        busy, done, err;
    logic        src_rd;
    logic [7:0]  src_addr;
    logic [31:0] src_data = '0;
    logic        dst_we;
    logic [7:0]  dst_addr;
    logic [31:0] dst_data;
    logic        sm_enable;
    logic [15:0] sm_in0, sm_in1, sm_exp0, sm_exp1, sm_num;
    logic [31:0] sm_exp_out = '0;
    logic        sm_exp_valid = 1'b0;
    logic        sm_recip_valid = 1'b0;
    logic [31:0] sm_out = '0;
    logic        sm_valid = 1'b0;

    logic [31:0] src_mem [256];
    logic [31:0] dst_mem [256];
    int n_run = 0;
    int n_fail = 0;
    int wcnt = 0, done_cnt = 0, err_cnt = 0, rd_cnt = 0;
    int eng_exp_limit = 1 << 30;
    int eng_p = 0, eng_in = 0, recip_cd = 0, drn = 0;
    bit drn_on = 1'b0;

    always #5 clk = ~clk;

    softmax_seq dut (
        .clk            (clk),
        .arst_n         (arst_n),
        .start          (start),
        .num            (num),
        .busy           (busy),
        .done           (done),
        .err            (err),
        .src_rd         (src_rd),
        .src_addr       (src_addr),
        .src_data       (src_data),
        .dst_we         (dst_we),
        .dst_addr       (dst_addr),
        .dst_data       (dst_data),
        .sm_enable      (sm_enable),
        .sm_in0         (sm_in0),
        .sm_in1         (sm_in1),
        .sm_exp0        (sm_exp0),
        .sm_exp1        (sm_exp1),
        .sm_num         (sm_num),
        .sm_exp_out     (sm_exp_out),
        .sm_exp_valid   (sm_exp_valid),
        .sm_recip_valid (sm_recip_valid),
        .sm_out         (sm_out),
        .sm_valid       (sm_valid)
    );

    // Source memory: data one cycle after the read strobe.
    always @(posedge clk) begin
        src_data <= src_rd ? src_mem[src_addr] : 32'h0;
    end

    // Result memory and event counters.
    always @(posedge clk) begin
        if (dst_we) begin
            dst_mem[dst_addr] = dst_data;
            wcnt++;
        end
        if (done)   done_cnt++;
        if (err)    err_cnt++;
        if (src_rd) rd_cnt++;
    end

    // Engine model: exp(x)=x+1, out(e)=3*e per element; recip two cycles after last exp.
    always @(posedge clk) begin
        sm_exp_valid   <= 1'b0;
        sm_recip_valid <= 1'b0;
        sm_valid       <= 1'b0;
        if (!sm_enable) begin
            eng_in   = 0;
            recip_cd = 0;
            drn_on   = 1'b0;
            drn      = 0;
        end else begin
            eng_p = int'(sm_num) >> 1;
            if (eng_in < eng_p) begin
                if (eng_in < eng_exp_limit) begin
                    sm_exp_valid <= 1'b1;
                    sm_exp_out   <= {sm_in0 + 16'd1, sm_in1 + 16'd1};
                end
                eng_in++;
                if (eng_in == eng_p) recip_cd = 2;
            end else if (recip_cd > 0) begin
                recip_cd--;
                if (recip_cd == 0) begin
                    sm_recip_valid <= 1'b1;
                    drn_on = 1'b1;
                    drn    = -2;
                end
            end else if (drn_on) begin
                if (drn < 0) begin
                    drn++;
                end else if (drn < eng_p) begin
                    sm_valid <= 1'b1;
                    sm_out   <= {16'(sm_exp0 * 3), 16'(sm_exp1 * 3)};
                    drn++;
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_run++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic start_job(input logic [15:0] n);
        @(negedge clk);
        start = 1'b1;
        num   = n;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (done) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic wait_err(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (err) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic clear_dst();
        for (int i = 0; i < 256; i++) dst_mem[i] = 32'hDEAD_BEEF;
    endtask

    initial begin
        bit ok;
        int w0, d0, e0, r0;

        arst_n = 1'b0;
        start  = 1'b0;
        num    = '0;
        src_mem[0] = {16'd1, 16'd2};
        src_mem[1] = {16'd3, 16'd4};
        src_mem[2] = {16'd5, 16'd6};
        src_mem[3] = {16'd7, 16'd8};
        clear_dst();
        tick(3);
        chk("rst_ctrl", {busy, done, err, src_rd, sm_enable, dst_we}, 6'b0);
        chk("rst_num", sm_num, 16'd0);
        arst_n = 1'b1;
        tick(1);

        // Basic N=8 job.
        w0 = wcnt; d0 = done_cnt;
        start_job(16'd8);
        chk("prime_busy", busy, 1'b1);
        chk("prime_rd", {src_rd, src_addr}, {1'b1, 8'd0});
        chk("prime_num", sm_num, 16'd8);
        wait_done(200, ok);
        chk("n8_done_seen", ok, 1'b1);
        chk("n8_done_busy_en", {busy, sm_enable}, 2'b11);
        tick(1);
        chk("n8_after_done", {busy, sm_enable, done}, 3'b000);
        chk("n8_writes", wcnt - w0, 4);
        chk("n8_done_cnt", done_cnt - d0, 1);
        chk("n8_dst0", dst_mem[0], 32'h0006_0009);
        chk("n8_dst1", dst_mem[1], 32'h000C_000F);
        chk("n8_dst2", dst_mem[2], 32'h0012_0015);
        chk("n8_dst3", dst_mem[3], 32'h0018_001B);

        // Odd N=3.
        w0 = wcnt; e0 = err_cnt; r0 = rd_cnt;
        clear_dst();
`ifdef SOFTMAX_SEQ_ODD_PAD_EN
        start_job(16'd3);
        chk("n3_pad_num", sm_num, 16'd4);
        wait_done(200, ok);
        chk("n3_pad_done_seen", ok, 1'b1);
        tick(1);
        chk("n3_pad_writes", wcnt - w0, 2);
        chk("n3_pad_dst0", dst_mem[0], 32'h0006_0009);
        chk("n3_pad_dst1", dst_mem[1], 32'h000C_0000);
`else
        start_job(16'd3);
        chk("n3_err", {err, busy}, 2'b10);
        tick(1);
        chk("n3_err_pulse", {err, busy}, 2'b00);
        chk("n3_no_rd", rd_cnt - r0, 0);
        chk("n3_err_cnt", err_cnt - e0, 1);
`endif

        // Start while running is ignored.
        w0 = wcnt; d0 = done_cnt;
        start_job(16'd8);
        for (int i = 0; i < 10 && !sm_enable; i++) @(negedge clk);
        start = 1'b1;
        num   = 16'd2;
        @(negedge clk);
        start = 1'b0;
        wait_done(200, ok);
        chk("busy_start_done_seen", ok, 1'b1);
        tick(5);
        chk("busy_start_writes", wcnt - w0, 4);
        chk("busy_start_done_cnt", done_cnt - d0, 1);
        chk("busy_start_idle", busy, 1'b0);

        // Engine reports recip with only 2 of 4 exps captured.
        w0 = wcnt; d0 = done_cnt;
        eng_exp_limit = 2;
        start_job(16'd8);
        wait_err(200, ok);
        chk("short_exp_err_seen", ok, 1'b1);
        chk("short_exp_idle", {busy, sm_enable}, 2'b00);
        tick(5);
        chk("short_exp_no_wr", wcnt - w0, 0);
        chk("short_exp_no_done", done_cnt - d0, 0);
        eng_exp_limit = 1 << 30;

        // Reset in the middle of draining.
        w0 = wcnt;
        start_job(16'd8);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (wcnt - w0 >= 2) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk("drain_two_writes", ok, 1'b1);
        arst_n = 1'b0;
        @(negedge clk);
        chk("mid_rst_ctrl", {busy, done, err, src_rd, sm_enable, dst_we}, 6'b0);
        chk("mid_rst_data", {sm_num, sm_exp0, sm_exp1, dst_addr}, 56'h0);
        arst_n = 1'b1;
        w0 = wcnt;
        tick(3);
        chk("mid_rst_no_wr", wcnt - w0, 0);
        clear_dst();
        w0 = wcnt;
        start_job(16'd4);
        wait_done(200, ok);
        chk("post_rst_done_seen", ok, 1'b1);
        tick(1);
        chk("post_rst_writes", wcnt - w0, 2);
        chk("post_rst_dst0", dst_mem[0], 32'h0006_0009);
        chk("post_rst_dst1", dst_mem[1], 32'h000C_000F);

        // Capacity boundary: 512 elements fills every pair slot, 514 does not fit.
        for (int k = 0; k < 256; k++) src_mem[k] = {16'(2 * k), 16'(2 * k + 1)};
        clear_dst();
        w0 = wcnt;
        start_job(16'd512);
        wait_done(2000, ok);
        chk("n512_done_seen", ok, 1'b1);
        tick(1);
        chk("n512_writes", wcnt - w0, 256);
        chk("n512_dst0", dst_mem[0], 32'h0003_0006);
        chk("n512_dst128", dst_mem[128], 32'h0303_0306);
        chk("n512_dst255", dst_mem[255], 32'h05FD_0600);
        e0 = err_cnt; r0 = rd_cnt;
        start_job(16'd514);
        chk("n514_err", {err, busy}, 2'b10);
        start_job(16'd1);
        chk("n1_err", {err, busy}, 2'b10);
        tick(1);
        chk("oversize_no_rd", rd_cnt - r0, 0);
        chk("oversize_err_cnt", err_cnt - e0, 2);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
